// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet round-robin stream arbiter.
// Contents: arbiter state enum, modulo-N pointer increment.
// No logic of its own; imported by the arbiter top level.
package stream_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   // Increment a requester index, wrapping at n rather than at a power of two.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_first_valid.sv
// Rotating-priority encoder: first set req bit at or after ptr, modulo NumInp.
// Latency: combinational, zero cycles. No backpressure (pure function).
// Ports: req_i requests, ptr_i start index, idx_o winner (ptr_i when none), any_o any request.
module rr_first_valid #(
   parameter int unsigned NumInp   = 4,
   parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
   input  logic [NumInp-1:0]   req_i,
   input  logic [IdxWidth-1:0] ptr_i,
   output logic [IdxWidth-1:0] idx_o,
   output logic                any_o
);

   int unsigned cand;

   // Walk offsets from the farthest to the nearest so the candidate closest
   // to ptr_i is the last one written and therefore wins.
   always_comb begin
      idx_o = ptr_i;
      any_o = |req_i;
      cand  = 0;
      for (int k = int'(NumInp) - 1; k >= 0; k--) begin
         cand = 32'(ptr_i) + 32'(k);
         if (cand >= NumInp) begin
            cand = cand - NumInp;
         end
         if (req_i[IdxWidth'(cand)]) begin
            idx_o = IdxWidth'(cand);
         end
      end
   end

endmodule

// File: rtl/stream_pkt_rr_arbiter.sv
// Round-robin arbiter merging NumInp valid/ready streams into one, packet-granular.
// Latency: combinational select, zero cycles input to output; no data registers.
// Backpressure: an offered beat locks the grant until accepted; in PktMode the
// grant is also held until the last beat of the packet is accepted.
// Ports: inp_* per-requester valid/ready/data/last, oup_* merged stream plus
// oup_idx_o (selected requester), clk_i, rst_i (synchronous, active-high).
module stream_pkt_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter int unsigned NumInp   = 4,
   parameter type         T        = logic,
   parameter bit          PktMode  = 1'b1,
   parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NumInp-1:0]     inp_valid_i,
   output logic [NumInp-1:0]     inp_ready_o,
   input  T     [NumInp-1:0]     inp_data_i,
   input  logic [NumInp-1:0]     inp_last_i,
   output logic                  oup_valid_o,
   input  logic                  oup_ready_i,
   output T                      oup_data_o,
   output logic                  oup_last_o,
   output logic [IdxWidth-1:0]   oup_idx_o
);

   arb_state_e          state_q, state_d;
   logic [IdxWidth-1:0] rr_q, rr_d;
   logic [IdxWidth-1:0] sel_q, sel_d;

   logic [IdxWidth-1:0] fv_idx;
   logic                fv_any;
   logic [IdxWidth-1:0] sel;
   logic                valid_raw;
   logic                last;
   logic                hs;
   logic                grant_en;

   rr_first_valid #(
      .NumInp   (NumInp),
      .IdxWidth (IdxWidth)
   ) u_first_valid (
      .req_i (inp_valid_i),
      .ptr_i (rr_q),
      .idx_o (fv_idx),
      .any_o (fv_any)
   );

   always_comb begin
      if (state_q == HOLD) begin
         sel       = sel_q;
         valid_raw = inp_valid_i[sel_q];
      end else begin
         // With no request fv_idx falls back to rr_q, which is what oup_idx_o shows.
         sel       = fv_idx;
         valid_raw = fv_any;
      end

      last = PktMode ? inp_last_i[sel] : 1'b1;
      hs   = valid_raw & oup_ready_i;

      // While locked, ready is presented even across a valid gap so the
      // locked requester sees a consistent ready; nobody else gets it.
      grant_en = (valid_raw | (state_q == HOLD)) & oup_ready_i & ~rst_i;
      for (int i = 0; i < int'(NumInp); i++) begin
         inp_ready_o[i] = grant_en & (sel == IdxWidth'(i));
      end

      oup_valid_o = valid_raw & ~rst_i;
      oup_idx_o   = rst_i ? '0 : sel;
      oup_data_o  = inp_data_i[sel];
      oup_last_o  = last;

      state_d = state_q;
      rr_d    = rr_q;
      sel_d   = sel_q;
      case (state_q)
         ARB: begin
            if (valid_raw) begin
               if (hs && last) begin
                  rr_d = IdxWidth'(rr_next(32'(sel), NumInp));
               end else begin
                  // Either mid-packet or stalled: lock onto this requester.
                  state_d = HOLD;
                  sel_d   = sel;
               end
            end
         end
         HOLD: begin
            if (hs && last) begin
               state_d = ARB;
               rr_d    = IdxWidth'(rr_next(32'(sel_q), NumInp));
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB;
         rr_q    <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         sel_q   <= sel_d;
      end
   end

   // An offered beat must not change until it is taken.
   a_oup_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (oup_valid_o && !oup_ready_i) |=>
         (oup_valid_o && $stable(oup_data_o) && $stable(oup_last_o) && $stable(oup_idx_o)));

   a_ready_onehot: assert property (@(posedge clk_i) $onehot0(inp_ready_o));

endmodule

// File: tb/tb_stream_pkt_rr_arbiter.sv
module tb_stream_pkt_rr_arbiter;

   localparam int NI = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [NI-1:0]       inp_valid;
   logic [NI-1:0]       inp_last;
   logic [NI-1:0][7:0]  inp_data;
   logic                oup_ready;

   logic [NI-1:0]       rdy_a, rdy_b;
   logic                ov_a, ov_b;
   logic [7:0]          od_a, od_b;
   logic                ol_a, ol_b;
   logic [1:0]          oi_a, oi_b;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: index 0 models the packet-mode DUT, index 1 the beat-mode DUT.
   int m_ptr[2];
   int m_lock[2];   // requester holding the grant, -1 when free
   int stall[2];    // requester whose beat was offered but not taken this cycle

   always #5 clk = ~clk;

   stream_pkt_rr_arbiter #(.NumInp(NI), .T(logic [7:0]), .PktMode(1'b1)) u_dut_a (
      .clk_i(clk), .rst_i(rst),
      .inp_valid_i(inp_valid), .inp_ready_o(rdy_a), .inp_data_i(inp_data), .inp_last_i(inp_last),
      .oup_valid_o(ov_a), .oup_ready_i(oup_ready), .oup_data_o(od_a), .oup_last_o(ol_a),
      .oup_idx_o(oi_a)
   );

   stream_pkt_rr_arbiter #(.NumInp(NI), .T(logic [7:0]), .PktMode(1'b0)) u_dut_b (
      .clk_i(clk), .rst_i(rst),
      .inp_valid_i(inp_valid), .inp_ready_o(rdy_b), .inp_data_i(inp_data), .inp_last_i(inp_last),
      .oup_valid_o(ov_b), .oup_ready_i(oup_ready), .oup_data_o(od_b), .oup_last_o(ol_b),
      .oup_idx_o(oi_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Predict one DUT's outputs from the current inputs, compare, then apply
   // the handshake that will happen at the coming clock edge.
   task automatic eval(input int d, input logic ov, input logic [NI-1:0] ir,
                       input logic [7:0] od, input logic ol, input logic [1:0] oi);
      int         own;
      int         c;
      bit         found;
      logic       ev;
      logic       el;
      logic [NI-1:0] er;
      string      nm;
      nm = (d == 0) ? "pkt" : "beat";
      if (m_lock[d] >= 0) begin
         own = m_lock[d];
      end else begin
         own   = m_ptr[d];
         found = 1'b0;
         for (int k = 0; k < NI; k++) begin
            c = (m_ptr[d] + k) % NI;
            if (!found && inp_valid[2'(c)]) begin
               own   = c;
               found = 1'b1;
            end
         end
      end
      ev = inp_valid[2'(own)];
      el = (d == 0) ? inp_last[2'(own)] : 1'b1;
      er = '0;
      if ((ev || m_lock[d] >= 0) && oup_ready) er[2'(own)] = 1'b1;
      chk({nm, "_valid"}, 32'(ov), 32'(ev));
      chk({nm, "_ready"}, 32'(ir), 32'(er));
      chk({nm, "_idx"},   32'(oi), 32'(own));
      if (ev) begin
         chk({nm, "_data"}, 32'(od), 32'(inp_data[2'(own)]));
         chk({nm, "_last"}, 32'(ol), 32'(el));
      end
      stall[d] = -1;
      if (ev && oup_ready) begin
         if (el) begin
            m_lock[d] = -1;
            m_ptr[d]  = (own + 1) % NI;
         end else begin
            m_lock[d] = own;
         end
      end else if (ev) begin
         m_lock[d] = own;
         stall[d]  = own;
      end
   endtask

   // One clock: check at the falling edge, then step past the rising edge.
   // xa/xb are directed expected indices for the two DUTs (-1 = model only).
   task automatic cyc(input int xa = -1, input int xb = -1);
      @(negedge clk);
      if (rst) begin
         chk("rst_valid_a", 32'(ov_a),  32'd0);
         chk("rst_ready_a", 32'(rdy_a), 32'd0);
         chk("rst_idx_a",   32'(oi_a),  32'd0);
         chk("rst_valid_b", 32'(ov_b),  32'd0);
         chk("rst_ready_b", 32'(rdy_b), 32'd0);
         chk("rst_idx_b",   32'(oi_b),  32'd0);
         for (int d = 0; d < 2; d++) begin
            m_ptr[d]  = 0;
            m_lock[d] = -1;
            stall[d]  = -1;
         end
      end else begin
         if (xa >= 0) chk("dir_idx_pkt",  32'(oi_a), 32'(xa));
         if (xb >= 0) chk("dir_idx_beat", 32'(oi_b), 32'(xb));
         eval(0, ov_a, rdy_a, od_a, ol_a, oi_a);
         eval(1, ov_b, rdy_b, od_b, ol_b, oi_b);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_ptr[d] = 0; m_lock[d] = -1; stall[d] = -1;
      end
      rst       = 1'b1;
      oup_ready = 1'b1;
      inp_valid = 4'hF;
      inp_last  = 4'hF;
      for (int i = 0; i < NI; i++) inp_data[i] = 8'(8'h10 + i);

      // Reset held with every input valid.
      repeat (3) cyc();
      rst = 1'b0;

      // Fairness with single beats: 0,1,2,3,0,1.
      cyc(0, 0); cyc(1, 1); cyc(2, 2); cyc(3, 3); cyc(0, 0); cyc(1, 1);

      // Packet lock: input 2 sends A,B,C while input 0 stays valid.
      inp_valid   = 4'b0101;
      inp_last    = 4'b0001;
      inp_data[2] = 8'h0A; cyc(2, 2);
      inp_data[2] = 8'h0B; cyc(2, 0);
      inp_data[2] = 8'h0C; inp_last = 4'b0101; cyc(2, 2);
      // Pointer now at 3: input 3 beats input 0, then input 0.
      inp_valid   = 4'b1001; inp_last = 4'hF; cyc(3, 3);
      inp_valid   = 4'b0001; cyc(0, 0);

      // Backpressure lock on input 1; input 0 joins while stalled.
      oup_ready   = 1'b0;
      inp_valid   = 4'b0010;
      inp_data[1] = 8'h55;
      cyc(1, 1);
      inp_valid   = 4'b0011;
      cyc(1, 1); cyc(1, 1); cyc(1, 1);
      oup_ready   = 1'b1;
      cyc(1, 1);

      // Wrap 3 -> 0.
      inp_valid = 4'b0100; cyc(2, 2);
      inp_valid = 4'b1000; cyc(3, 3);
      inp_valid = 4'hF;    cyc(0, 0);

      // Mid-packet valid gap on the locked input 1.
      inp_valid = 4'b0010; inp_last = 4'b1101; cyc(1, 1);
      inp_valid = 4'b0001; cyc(1, -1); cyc(1, -1);
      inp_valid = 4'b0011; inp_last = 4'hF; cyc(1, -1);

      // Reset in the middle of a packet drops the lock.
      inp_valid = 4'b1000; inp_last = 4'b0111; cyc(3, -1);
      rst = 1'b1; cyc();
      rst = 1'b0;
      inp_valid = 4'b0010; inp_last = 4'hF; cyc(1, 1);

      // Two-beat packets on 0 and 1: packet mode stays on 0, beat mode interleaves.
      inp_valid   = 4'b0011;
      inp_last    = 4'b0000;
      inp_data[0] = 8'h20;
      inp_data[1] = 8'h21;
      cyc(0, 0); cyc(0, 1); cyc(0, 0); cyc(0, 1);
      inp_last    = 4'hF;
      cyc(0, 0);

      // Randomized traffic; a stalled requester keeps its beat unchanged.
      repeat (600) begin
         oup_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NI; i++) begin
            if (stall[0] != i && stall[1] != i) begin
               inp_valid[i] = 1'($urandom_range(0, 1));
               inp_last[i]  = ($urandom_range(0, 2) == 0);
               inp_data[i]  = 8'($urandom);
            end
         end
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
